log_event_buffer: RTL and testbench
===================================

LOG_EVENT_BUFFER -- requirements
Module: log_event_buffer

Interface
REQ-001 Parameter LOG_DATA_BITW, default 32: width of event payload; multiple of 32.
REQ-002 Parameter FIFO_DEPTH, default 8: event buffer entries; power of two, >= 2.
REQ-003 Parameter DROP_CNT_BITW, default 16: width of dropped-event counter.
REQ-004 Clk_CI  in  1  sole clock; all state updates on its rising edge.
REQ-005 Rst_RBI  in  1  asynchronous, active-low reset.
REQ-006 EvtValid_SI  in  1  event present this cycle.
REQ-007 EvtData_DI  in  LOG_DATA_BITW  event payload, sampled with EvtValid_SI.
REQ-008 EvtEn_SI  in  1  capture enable; events ignored (not counted) when low.
REQ-009 Flush_SI  in  1  one-cycle pulse requesting discard of all buffered events.
REQ-010 LoggerReady_SI  in  1  downstream logger ready (its Ready_SO).
REQ-011 LogData_DO  out  LOG_DATA_BITW  payload presented to logger LogData_DI.
REQ-012 LogTrigger_SO  out  1  one-cycle log request to logger LogTrigger_SI.
REQ-013 DropCnt_DO  out  DROP_CNT_BITW  count of events lost to overflow.
REQ-014 DropClr_SI  in  1  synchronous clear of DropCnt_DO.
REQ-015 Empty_SO  out  1  buffer holds no events.
REQ-016 Overflow_SO  out  1  sticky: at least one drop since last DropClr_SI.

Function
REQ-017 Buffer SHALL be a FIFO of FIFO_DEPTH entries with count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be RUN, STALL, FLUSH; reset state RUN.
REQ-019 Push: EvtValid_SI && EvtEn_SI && state != FLUSH && (count < FIFO_DEPTH || pop this cycle) SHALL write EvtData_DI at write pointer.
REQ-020 Drop: EvtValid_SI && EvtEn_SI && push not possible (full without pop, or state FLUSH) SHALL increment DropCnt_DO and set Overflow_SO.
REQ-021 DropCnt_DO SHALL saturate at all-ones; DropClr_SI clears it and Overflow_SO, and clear takes priority over a same-cycle drop.
REQ-022 Pop in RUN: count > 0 && LoggerReady_SI SHALL read head entry; next cycle LogTrigger_SO = 1 and LogData_DO = that entry (registered outputs).
REQ-023 At most one pop per cycle; LogTrigger_SO SHALL be 0 in any cycle not following a pop.
REQ-024 Minimum latency EvtValid_SI sampled at edge N -> LogTrigger_SO high after edge N+1 (empty buffer, LoggerReady_SI high).
REQ-025 LogData_DO SHALL hold its last value when LogTrigger_SO is 0.
REQ-026 RUN -> STALL when LoggerReady_SI = 0; STALL -> RUN when LoggerReady_SI = 1; no pops in STALL; pushes continue.
REQ-027 Any state -> FLUSH on Flush_SI (priority over all other transitions); FLUSH discards one entry per cycle, no trigger; FLUSH -> RUN when count reaches 0 (immediately next cycle if already empty).
REQ-028 Simultaneous push and pop SHALL leave count unchanged; full with same-cycle pop SHALL accept the push without drop.
REQ-029 Empty_SO SHALL equal (count == 0), combinational from registered count.

Reset
REQ-030 On Rst_RBI low, asynchronously: state RUN, pointers and count 0, LogTrigger_SO 0, LogData_DO 0, DropCnt_DO 0, Overflow_SO 0, Empty_SO 1.
REQ-031 Reset mid-operation SHALL discard buffered events without emitting triggers; FIFO storage need not be reset.

Verification
REQ-032 Single event 0xA5A5_0001, LoggerReady_SI = 1 -> LogTrigger_SO high exactly one cycle, two edges later, LogData_DO = 0xA5A5_0001.
REQ-033 LoggerReady_SI = 0, 10 back-to-back events, depth 8 -> 8 buffered, DropCnt_DO = 2, Overflow_SO = 1; ready raised -> 8 triggers on consecutive cycles in order.
REQ-034 Full buffer, LoggerReady_SI = 1, continuous events -> one push and one pop per cycle, DropCnt_DO stays 0.
REQ-035 5 entries buffered, Flush_SI pulse with concurrent event -> event dropped (DropCnt_DO +1), no triggers, Empty_SO = 1 after 5 cycles, state RUN.
REQ-036 DropCnt_DO at all-ones, further drop -> stays all-ones; DropClr_SI with simultaneous drop -> DropCnt_DO = 0, Overflow_SO = 0.
REQ-037 Rst_RBI asserted between clock edges with 3 entries buffered -> outputs at reset values immediately, no trigger after release.

Source files
------------

// File: rtl/log_event_buffer.sv
// Event capture FIFO in front of a single-request logger: buffers events while
// the logger is busy, counts events lost to overflow and supports bulk flush.
module log_event_buffer #(
  parameter int LOG_DATA_BITW = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int DROP_CNT_BITW = 16
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic                     EvtValid_SI,
  input  logic [LOG_DATA_BITW-1:0] EvtData_DI,
  input  logic                     EvtEn_SI,
  input  logic                     Flush_SI,
  input  logic                     LoggerReady_SI,
  output logic [LOG_DATA_BITW-1:0] LogData_DO,
  output logic                     LogTrigger_SO,
  output logic [DROP_CNT_BITW-1:0] DropCnt_DO,
  input  logic                     DropClr_SI,
  output logic                     Empty_SO,
  output logic                     Overflow_SO
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [LOG_DATA_BITW-1:0] mem [FIFO_DEPTH];

  logic evt;
  logic pop;
  logic discard;
  logic push;
  logic drop;

  // A flush request blocks pushes and pops in its own cycle as well, so an
  // event arriving together with the pulse is dropped and nothing is emitted.
  assign evt     = EvtValid_SI && EvtEn_SI;
  assign pop     = (state == RUN) && !Flush_SI && (count != '0) && LoggerReady_SI;
  assign discard = (state == FLUSH) && (count != '0);
  assign push    = evt && (state != FLUSH) && !Flush_SI
                   && ((count < CNT_W'(FIFO_DEPTH)) || pop);
  assign drop    = evt && !push;

  assign Empty_SO = (count == '0);

  // NOTE: the storage array has no reset; stale entries are unreachable once
  // the pointers and count are cleared, and leaving it out keeps it a RAM.
  always_ff @(posedge Clk_CI) begin
    if (push) mem[wr_ptr] <= EvtData_DI;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      LogTrigger_SO <= 1'b0;
      LogData_DO    <= '0;
      DropCnt_DO    <= '0;
      Overflow_SO   <= 1'b0;
    end else begin
      if (Flush_SI) begin
        state <= FLUSH;
      end else begin
        case (state)
          RUN:     state <= LoggerReady_SI ? RUN : STALL;
          STALL:   state <= LoggerReady_SI ? RUN : STALL;
          FLUSH:   state <= (count <= CNT_W'(1)) ? RUN : FLUSH;
          default: state <= RUN;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop || discard) rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !(pop || discard)) begin
        count <= count + CNT_W'(1);
      end else if (!push && (pop || discard)) begin
        count <= count - CNT_W'(1);
      end

      LogTrigger_SO <= pop;
      if (pop) LogData_DO <= mem[rd_ptr];

      if (DropClr_SI) begin
        DropCnt_DO  <= '0;
        Overflow_SO <= 1'b0;
      end else if (drop) begin
        if (DropCnt_DO != '1) DropCnt_DO <= DropCnt_DO + DROP_CNT_BITW'(1);
        Overflow_SO <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log_event_buffer.sv
// Self-checking bench for log_event_buffer: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_log_event_buffer;

  localparam int DEPTH = 8;
  localparam int DCW   = 4;
  localparam logic [DCW-1:0] DMAX = '1;

  logic            Clk_CI = 1'b0;
  logic            Rst_RBI;
  logic            EvtValid_SI;
  logic [31:0]     EvtData_DI;
  logic            EvtEn_SI;
  logic            Flush_SI;
  logic            LoggerReady_SI;
  logic [31:0]     LogData_DO;
  logic            LogTrigger_SO;
  logic [DCW-1:0]  DropCnt_DO;
  logic            DropClr_SI;
  logic            Empty_SO;
  logic            Overflow_SO;

  int total = 0;
  int bad   = 0;

  // Behavioural model: a queue plus a mode word (0 run, 1 stall, 2 flush).
  logic [31:0]    q[$];
  int             m_mode;
  logic           m_trig;
  logic [31:0]    m_data;
  logic [DCW-1:0] m_drop;
  logic           m_ovf;
  int             trig_seen;

  log_event_buffer #(
    .LOG_DATA_BITW(32),
    .FIFO_DEPTH   (DEPTH),
    .DROP_CNT_BITW(DCW)
  ) dut (
    .Clk_CI        (Clk_CI),
    .Rst_RBI       (Rst_RBI),
    .EvtValid_SI   (EvtValid_SI),
    .EvtData_DI    (EvtData_DI),
    .EvtEn_SI      (EvtEn_SI),
    .Flush_SI      (Flush_SI),
    .LoggerReady_SI(LoggerReady_SI),
    .LogData_DO    (LogData_DO),
    .LogTrigger_SO (LogTrigger_SO),
    .DropCnt_DO    (DropCnt_DO),
    .DropClr_SI    (DropClr_SI),
    .Empty_SO      (Empty_SO),
    .Overflow_SO   (Overflow_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_trig = 1'b0;
    m_data = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic v, en, input logic [31:0] d,
                            input logic fl, rdy, clr);
    bit pop, push, drop, disc;
    pop  = (m_mode == 0) && !fl && (q.size() > 0) && rdy;
    disc = (m_mode == 2) && (q.size() > 0);
    push = v && en && (m_mode != 2) && !fl && ((q.size() < DEPTH) || pop);
    drop = v && en && !push;
    if (fl)               m_mode = 2;
    else if (m_mode == 2) m_mode = (q.size() <= 1) ? 0 : 2;
    else                  m_mode = rdy ? 0 : 1;
    m_trig = pop;
    if (pop) m_data = q.pop_front();
    if (disc) void'(q.pop_front());
    if (push) q.push_back(d);
    if (clr) begin
      m_drop = '0;
      m_ovf  = 1'b0;
    end else if (drop) begin
      if (m_drop != DMAX) m_drop = m_drop + 1'b1;
      m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic v, en, input logic [31:0] d,
                      input logic fl, rdy, clr);
    EvtValid_SI    = v;
    EvtEn_SI       = en;
    EvtData_DI     = d;
    Flush_SI       = fl;
    LoggerReady_SI = rdy;
    DropClr_SI     = clr;
    model_edge(v, en, d, fl, rdy, clr);
    @(posedge Clk_CI);
    #1;
    if (LogTrigger_SO === 1'b1) trig_seen++;
    check("trigger", 32'(LogTrigger_SO), 32'(m_trig));
    check("data",    LogData_DO,         m_data);
    check("dropcnt", 32'(DropCnt_DO),    32'(m_drop));
    check("overflow",32'(Overflow_SO),   32'(m_ovf));
    check("empty",   32'(Empty_SO),      32'(q.size() == 0));
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    Rst_RBI        = 1'b0;
    EvtValid_SI    = 1'b0;
    EvtEn_SI       = 1'b0;
    EvtData_DI     = '0;
    Flush_SI       = 1'b0;
    LoggerReady_SI = 1'b0;
    DropClr_SI     = 1'b0;
    trig_seen      = 0;
    model_reset();
    #12;
    check("rst_trigger",  32'(LogTrigger_SO), 32'h0);
    check("rst_data",     LogData_DO,         32'h0);
    check("rst_dropcnt",  32'(DropCnt_DO),    32'h0);
    check("rst_overflow", 32'(Overflow_SO),   32'h0);
    check("rst_empty",    32'(Empty_SO),      32'h1);
    Rst_RBI = 1'b1;

    // Single event with logger ready: trigger two edges later, for one cycle.
    step(1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
    check("single_no_early_trig", 32'(LogTrigger_SO), 32'h0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("single_trig",  32'(LogTrigger_SO), 32'h1);
    check("single_data",  LogData_DO,         32'hA5A5_0001);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("single_trig_once", 32'(LogTrigger_SO), 32'h0);

    // Disabled capture: event neither buffered nor counted.
    step(1'b1, 1'b0, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Logger busy, 10 back-to-back events into depth 8.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0);
    check("burst_dropcnt",  32'(DropCnt_DO),  32'd2);
    check("burst_overflow", 32'(Overflow_SO), 32'h1);
    trig_seen = 0;
    idle(1'b1, 10);
    check("burst_drain_count", 32'(trig_seen), 32'd8);

    // Full buffer with ready logger and continuous events: no drops.
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'hC100_0000 + i, 1'b0, 1'b1, 1'b0);
    check("stream_dropcnt", 32'(DropCnt_DO), 32'd0);
    idle(1'b1, 12);

    // Flush with five buffered entries and a concurrent event.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    trig_seen = 0;
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    check("flush_drop", 32'(DropCnt_DO), 32'd1);
    idle(1'b1, 5);
    check("flush_empty",  32'(Empty_SO),      32'h1);
    check("flush_no_trig", 32'(trig_seen),    32'd0);
    step(1'b1, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1);
    check("flush_back_to_run", 32'(LogTrigger_SO), 32'h1);

    // Drop counter saturation, then clear racing a drop.
    for (int i = 0; i < DEPTH + 20; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    check("sat_dropcnt", 32'(DropCnt_DO), 32'(DMAX));
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    check("sat_hold", 32'(DropCnt_DO), 32'(DMAX));
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    check("clr_dropcnt",  32'(DropCnt_DO),  32'h0);
    check("clr_overflow", 32'(Overflow_SO), 32'h0);
    idle(1'b1, DEPTH + 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) != 0, $urandom,
           ($urandom % 40) == 0, ($urandom % 3) != 0, ($urandom % 50) == 0);
    end
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, DEPTH + 2);

    // Reset between edges with three entries buffered.
    step(1'b1, 1'b1, 32'hE000_0001, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hE100_0000 + i, 1'b0, 1'b0, 1'b0);
    #2;
    Rst_RBI = 1'b0;
    #1;
    check("mid_rst_trigger",  32'(LogTrigger_SO), 32'h0);
    check("mid_rst_data",     LogData_DO,         32'h0);
    check("mid_rst_dropcnt",  32'(DropCnt_DO),    32'h0);
    check("mid_rst_overflow", 32'(Overflow_SO),   32'h0);
    check("mid_rst_empty",    32'(Empty_SO),      32'h1);
    #1;
    Rst_RBI = 1'b1;
    model_reset();
    trig_seen = 0;
    idle(1'b1, 5);
    check("mid_rst_no_trig", 32'(trig_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
